// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift, rotate, load, clear, plus a burst
// engine that shifts left for a programmed count with busy/done status.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned LW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [2:0]       mode_i,
  input  logic             sin_lsb_i,
  input  logic             sin_msb_i,
  input  logic [WIDTH-1:0] pdata_i,
  input  logic [LW-1:0]    len_i,
  output logic [WIDTH-1:0] sr_o,
  output logic             sout_msb_o,
  output logic             sout_lsb_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_ROL   = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_BURST = 3'b111
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] shl_c;
  mode_e            mode_c;

  assign shl_c  = {sr_q[WIDTH-2:0], sin_lsb_i};
  assign mode_c = mode_e'(mode_i);

  // Next-state: idle decodes commands; busy shifts until the count expires
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          unique case (mode_c)
            MODE_HOLD:  sr_d = sr_q;
            MODE_SHL:   sr_d = shl_c;
            MODE_SHR:   sr_d = {sin_msb_i, sr_q[WIDTH-1:1]};
            MODE_ROL:   sr_d = {sr_q[WIDTH-2:0], sr_q[WIDTH-1]};
            MODE_ROR:   sr_d = {sr_q[0], sr_q[WIDTH-1:1]};
            MODE_LOAD:  sr_d = pdata_i;
            MODE_CLEAR: sr_d = '0;
            MODE_BURST: begin
              if (len_i != '0) begin
                sr_d  = shl_c;
                cnt_d = len_i - LW'(1);
                if (len_i == LW'(1)) done_d  = 1'b1;
                else                 state_d = ST_BUSY;
              end
            end
          endcase
        end
      end
      ST_BUSY: begin
        if (en_i && (mode_c == MODE_CLEAR)) begin
          // Abort: no done pulse
          sr_d    = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          sr_d  = shl_c;
          cnt_d = cnt_q - LW'(1);
          if (cnt_q == LW'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign sr_o       = sr_q;
  assign sout_msb_o = sr_q[WIDTH-1];
  assign sout_lsb_o = sr_q[0];
  assign busy_o     = (state_q == ST_BUSY);
  assign done_o     = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed plan vectors and random traffic, both
// checked against a remaining-shift-count reference model.
module tb_univ_shift_reg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LW    = $clog2(WIDTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             en_i;
  logic [2:0]       mode_i;
  logic             sin_lsb_i;
  logic             sin_msb_i;
  logic [WIDTH-1:0] pdata_i;
  logic [LW-1:0]    len_i;
  logic [WIDTH-1:0] sr_o;
  logic             sout_msb_o;
  logic             sout_lsb_o;
  logic             busy_o;
  logic             done_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: register value, shifts still owed by a burst, done flag
  logic [WIDTH-1:0] m_sr;
  int               m_rem;
  logic             m_done;

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .mode_i(mode_i),
    .sin_lsb_i(sin_lsb_i), .sin_msb_i(sin_msb_i), .pdata_i(pdata_i),
    .len_i(len_i), .sr_o(sr_o), .sout_msb_o(sout_msb_o),
    .sout_lsb_o(sout_lsb_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_edge();
    logic [WIDTH-1:0] v;
    v = m_sr;
    m_done = 1'b0;
    if (rst) begin
      m_sr = '0; m_rem = 0;
      return;
    end
    if (m_rem > 0) begin
      if (en_i && mode_i == 3'd6) begin
        m_sr = '0; m_rem = 0;
      end else begin
        m_sr = WIDTH'((32'(v) << 1) | 32'(sin_lsb_i));
        m_rem--;
        if (m_rem == 0) m_done = 1'b1;
      end
    end else if (en_i) begin
      case (mode_i)
        3'd1: m_sr = WIDTH'((32'(v) << 1) | 32'(sin_lsb_i));
        3'd2: m_sr = WIDTH'((32'(v) >> 1) | (32'(sin_msb_i) << (WIDTH - 1)));
        3'd3: m_sr = WIDTH'((32'(v) << 1) | (32'(v) >> (WIDTH - 1)));
        3'd4: m_sr = WIDTH'((32'(v) >> 1) | (32'(v[0]) << (WIDTH - 1)));
        3'd5: m_sr = pdata_i;
        3'd6: m_sr = '0;
        3'd7: begin
          if (int'(len_i) > 0) begin
            m_sr  = WIDTH'((32'(v) << 1) | 32'(sin_lsb_i));
            m_rem = int'(len_i) - 1;
            if (m_rem == 0) m_done = 1'b1;
          end
        end
        default: ;
      endcase
    end
  endfunction

  // One clock: model follows the edge, outputs compared 1 time unit later
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("sr", 32'(sr_o), 32'(m_sr));
    check("busy", 32'(busy_o), 32'(m_rem > 0));
    check("done", 32'(done_o), 32'(m_done));
    check("sout_msb", 32'(sout_msb_o), 32'(m_sr[WIDTH-1]));
    check("sout_lsb", 32'(sout_lsb_o), 32'(m_sr[0]));
  endtask

  task automatic cmd(input logic [2:0] m, input logic [WIDTH-1:0] d, input logic [LW-1:0] n);
    en_i = 1'b1; mode_i = m; pdata_i = d; len_i = n;
    step();
    en_i = 1'b0;
  endtask

  int busy_cnt;
  int done_cnt;

  initial begin
    rst = 1'b1; en_i = 1'b0; mode_i = '0; sin_lsb_i = 1'b0; sin_msb_i = 1'b0;
    pdata_i = '0; len_i = '0;
    m_sr = '1; m_rem = 0; m_done = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_sr", 32'(sr_o), 32'h00);
    check("rst_busy", 32'(busy_o), 32'h0);

    // Load then hold
    cmd(3'd5, 8'hA5, '0);
    check("load", 32'(sr_o), 32'hA5);
    for (int i = 0; i < 8; i++) cmd(3'd0, 8'h00, '0);
    check("hold", 32'(sr_o), 32'hA5);

    // Rotate / shift sequence
    cmd(3'd5, 8'h81, '0);
    cmd(3'd3, '0, '0);  check("rol", 32'(sr_o), 32'h03);
    cmd(3'd4, '0, '0);  check("ror", 32'(sr_o), 32'h81);
    sin_msb_i = 1'b1;
    cmd(3'd2, '0, '0);  check("shr", 32'(sr_o), 32'hC0);
    sin_lsb_i = 1'b0;
    cmd(3'd1, '0, '0);  check("shl", 32'(sr_o), 32'h80);
    check("msb_out", 32'(sout_msb_o), 32'h1);
    check("lsb_out", 32'(sout_lsb_o), 32'h0);

    // Burst of 3 filling ones
    cmd(3'd5, 8'h00, '0);
    sin_lsb_i = 1'b1;
    cmd(3'd7, '0, LW'(3));
    check("b3_0", 32'(sr_o), 32'h01);
    busy_cnt = int'(busy_o); done_cnt = int'(done_o);
    step(); check("b3_1", 32'(sr_o), 32'h03);
    busy_cnt += int'(busy_o); done_cnt += int'(done_o);
    step(); check("b3_2", 32'(sr_o), 32'h07);
    check("b3_done_at_07", 32'(done_o), 32'h1);
    busy_cnt += int'(busy_o); done_cnt += int'(done_o);
    step();
    busy_cnt += int'(busy_o); done_cnt += int'(done_o);
    check("b3_busy_cycles", 32'(busy_cnt), 32'd2);
    check("b3_done_pulses", 32'(done_cnt), 32'd1);

    // Burst of 1 and burst of 0
    sin_lsb_i = 1'b0;
    cmd(3'd5, 8'h80, '0);
    cmd(3'd7, '0, LW'(1));
    check("b1_sr", 32'(sr_o), 32'h00);
    check("b1_done", 32'(done_o), 32'h1);
    check("b1_busy", 32'(busy_o), 32'h0);
    cmd(3'd5, 8'h5A, '0);
    cmd(3'd7, '0, LW'(0));
    check("b0_sr", 32'(sr_o), 32'h5A);
    check("b0_done", 32'(done_o), 32'h0);

    // Abort a long burst; loads while busy are ignored
    cmd(3'd5, 8'hFF, '0);
    cmd(3'd7, '0, LW'(10));
    cmd(3'd5, 8'h12, '0);
    cmd(3'd5, 8'h34, '0);
    check("ab_ignore_load", 32'(sr_o), 32'hF8);
    cmd(3'd6, '0, '0);
    check("ab_sr", 32'(sr_o), 32'h00);
    check("ab_busy", 32'(busy_o), 32'h0);
    for (int i = 0; i < 8; i++) step();
    check("ab_no_done", 32'(done_o), 32'h0);

    // Reset during a burst, then a normal command
    cmd(3'd5, 8'hC3, '0);
    sin_lsb_i = 1'b1;
    cmd(3'd7, '0, LW'(5));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rb_sr", 32'(sr_o), 32'h00);
    check("rb_busy", 32'(busy_o), 32'h0);
    cmd(3'd5, 8'h3C, '0);
    check("rb_after", 32'(sr_o), 32'h3C);

    // Random traffic against the model, including long bursts and resets
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      en_i      = ($urandom_range(0, 3) != 0);
      mode_i    = 3'($urandom_range(0, 7));
      sin_lsb_i = 1'($urandom);
      sin_msb_i = 1'($urandom);
      pdata_i   = WIDTH'($urandom);
      len_i     = LW'($urandom);
      step();
    end
    rst = 1'b0; en_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
